// File: rtl/ser2par_rx.sv
// ser2par_rx - serial-to-parallel receiver for the single-wire serial word link.
//
// Collects one wire bit per cycle in which sin_en is high. A bit sampled with
// sof high always starts a new word as bit 0, discarding any partial word.
// When the last bit of a word arrives, the word is loaded into a valid/ready
// output register. If that register is still occupied and is not being
// drained in the same cycle, the word is dropped and a sticky overrun flag is
// raised.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  0: first wire bit lands in dout[0]; 1: first wire bit lands in dout[WIDTH-1]
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   sin          serial data bit, sampled when sin_en=1
//   sin_en       bit strobe
//   sof          start of frame, qualified by sin_en
//   dout         received word, stable while dout_valid=1
//   dout_valid   word available, held until accepted
//   dout_ready   consumer accept
//   busy         a frame is partially received
//   overrun      sticky: a completed word was dropped
//   overrun_clr  clears overrun (a same-cycle set wins)
//
// All outputs come straight from registers.

module ser2par_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    // The counter only ever holds 0..WIDTH-1.
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overrun_q, overrun_d;

    logic [WIDTH-1:0]  sh_shifted;
    logic              word_done;
    logic              out_free;
    logic              deliver;
    logic              drop;

    // Shift register with the current wire bit already folded in; on the
    // final-bit cycle this is the completed word.
    always_comb begin
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], sin};
        end else begin
            sh_shifted = {sin, sh_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, bit counter and shift register
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        word_done = 1'b0;

        if (sin_en) begin
            unique case (state_q)
                StIdle: begin
                    // Bits outside a frame are ignored until a marker arrives.
                    if (sof) begin
                        sh_d    = sh_shifted;
                        cnt_d   = CntOne;
                        state_d = StShift;
                    end
                end

                StShift: begin
                    if (sof) begin
                        // Resync: drop the partial word without flagging it.
                        sh_d  = sh_shifted;
                        cnt_d = CntOne;
                    end else if (cnt_q == CntLast) begin
                        sh_d      = sh_shifted;
                        cnt_d     = '0;
                        word_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        sh_d  = sh_shifted;
                        cnt_d = cnt_q + CntOne;
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register, handshake and overrun next state
    // ------------------------------------------------------------------
    always_comb begin
        // The slot is free when empty or being drained this very cycle, which
        // lets back-to-back words stream without a bubble.
        out_free     = !dout_valid_q || dout_ready;
        deliver      = word_done && out_free;
        drop         = word_done && !out_free;

        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        if (deliver) begin
            dout_d       = sh_shifted;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Set takes priority over clear so a drop is never lost.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            sh_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == StShift);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ser2par_rx.sv
// Bench for ser2par_rx. Two instances share all inputs: one LSB-first, one
// MSB-first. For each full frame driven, the expected word for each instance
// is pushed to its queue; words are popped and compared when accepted.

module tb_ser2par_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_en;
    logic         sof;
    logic         dout_ready;
    logic         overrun_clr;

    logic [W-1:0] dout_l, dout_m;
    logic         valid_l, valid_m;
    logic         busy_l, busy_m;
    logic         ovr_l, ovr_m;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q_l[$];
    logic [W-1:0] q_m[$];
    bit           hold_chk = 1'b0;

    always #5 clk = ~clk;

    ser2par_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_en      (sin_en),
        .sof         (sof),
        .dout        (dout_l),
        .dout_valid  (valid_l),
        .dout_ready  (dout_ready),
        .busy        (busy_l),
        .overrun     (ovr_l),
        .overrun_clr (overrun_clr)
    );

    ser2par_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_en      (sin_en),
        .sof         (sof),
        .dout        (dout_m),
        .dout_valid  (valid_m),
        .dout_ready  (dout_ready),
        .busy        (busy_m),
        .overrun     (ovr_m),
        .overrun_clr (overrun_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one full frame. seq holds the wire bits in time order (seq[0] first).
    task automatic send_word(input logic [W-1:0] w, input bit msb, input int max_gap,
                             input bit push, input bit rdy_last, input bit clr_last,
                             input bit chk_busy);
        logic [W-1:0] seq;
        for (int i = 0; i < W; i++) seq[i] = msb ? w[W-1-i] : w[i];
        if (push) begin
            q_l.push_back(seq);
            q_m.push_back(rev(seq));
        end
        for (int i = 0; i < W; i++) begin
            if (max_gap > 0) begin
                sin_en = 1'b0;
                sof    = 1'b0;
                repeat ($urandom_range(0, max_gap)) tick();
            end
            sin    = seq[i];
            sin_en = 1'b1;
            sof    = (i == 0);
            if (i == W - 1) begin
                if (rdy_last) dout_ready = 1'b1;
                if (clr_last) overrun_clr = 1'b1;
            end
            if (chk_busy) check_eq("busy_during_frame", 32'(busy_l), 32'(i != 0));
            tick();
        end
        sin_en      = 1'b0;
        sof         = 1'b0;
        overrun_clr = 1'b0;
        if (rdy_last) dout_ready = 1'b0;
        if (chk_busy) check_eq("busy_after_frame", 32'(busy_l), 32'd0);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            sin    = 1'($urandom);
            sin_en = 1'b1;
            sof    = (i == 0);
            tick();
        end
        sin_en = 1'b0;
        sof    = 1'b0;
    endtask

    // Scoreboard: compare every accepted word against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_chk) check_eq("b2b_valid_held", 32'(valid_l), 32'd1);
            if (valid_l && dout_ready) begin
                if (q_l.size() == 0) check_eq("lsb_unexpected_valid", 32'(valid_l), 32'd0);
                else check_eq("lsb_word", 32'(dout_l), 32'(q_l.pop_front()));
            end
            if (valid_m && dout_ready) begin
                if (q_m.size() == 0) check_eq("msb_unexpected_valid", 32'(valid_m), 32'd0);
                else check_eq("msb_word", 32'(dout_m), 32'(q_m.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        sin         = 1'b0;
        sin_en      = 1'b1;
        sof         = 1'b1;
        dout_ready  = 1'b1;
        overrun_clr = 1'b0;

        // Reset with junk on the wire
        repeat (2) begin
            sin = 1'($urandom);
            sof = 1'($urandom);
            tick();
        end
        rst    = 1'b0;
        sin_en = 1'b0;
        sof    = 1'b0;
        check_eq("rst_dout_l", 32'(dout_l), 32'd0);
        check_eq("rst_valid_l", 32'(valid_l), 32'd0);
        check_eq("rst_busy_l", 32'(busy_l), 32'd0);
        check_eq("rst_ovr_l", 32'(ovr_l), 32'd0);
        check_eq("rst_dout_m", 32'(dout_m), 32'd0);
        check_eq("rst_valid_m", 32'(valid_m), 32'd0);
        check_eq("rst_busy_m", 32'(busy_m), 32'd0);
        check_eq("rst_ovr_m", 32'(ovr_m), 32'd0);
        tick();

        // LSB-first frame, consecutive strobes, ready held high
        send_word(8'hA5, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("a5_valid", 32'(valid_l), 32'd1);
        check_eq("a5_dout", 32'(dout_l), 32'hA5);
        tick();
        check_eq("a5_valid_one_cycle", 32'(valid_l), 32'd0);

        // Gapped MSB-first frame
        send_word(8'h3C, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("3c_valid_m", 32'(valid_m), 32'd1);
        check_eq("3c_dout_m", 32'(dout_m), 32'h3C);
        tick();

        // Backpressure and overrun
        dout_ready = 1'b0;
        send_word(8'h11, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bp_dout_l", 32'(dout_l), 32'h11);
        check_eq("bp_dout_m", 32'(dout_m), 32'(rev(8'h11)));
        check_eq("bp_valid_l", 32'(valid_l), 32'd1);
        check_eq("ovr_set_l", 32'(ovr_l), 32'd1);
        check_eq("ovr_set_m", 32'(ovr_m), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_eq("ovr_clr_l", 32'(ovr_l), 32'd0);
        check_eq("ovr_clr_m", 32'(ovr_m), 32'd0);
        send_word(8'h33, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovr_set_wins_l", 32'(ovr_l), 32'd1);
        check_eq("ovr_set_wins_m", 32'(ovr_m), 32'd1);
        check_eq("bp_dout_kept", 32'(dout_l), 32'h11);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        dout_ready  = 1'b1;
        tick();
        check_eq("bp_drain_valid", 32'(valid_l), 32'd0);
        check_eq("bp_drain_dout", 32'(dout_l), 32'h11);

        // Resync mid-frame, then reset mid-frame
        send_partial(5);
        send_word(8'h96, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("resync_dout", 32'(dout_l), 32'h96);
        check_eq("resync_ovr", 32'(ovr_l), 32'd0);
        tick();
        send_partial(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy_l), 32'd0);
        check_eq("midrst_valid", 32'(valid_l), 32'd0);
        send_word(8'h0F, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_dout", 32'(dout_l), 32'h0F);
        tick();

        // Back-to-back, ready only on the second word's final bit
        dout_ready = 1'b0;
        send_word(8'hAA, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_chk = 1'b1;
        send_word(8'h55, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold_chk = 1'b0;
        check_eq("b2b_valid", 32'(valid_l), 32'd1);
        check_eq("b2b_dout_l", 32'(dout_l), 32'h55);
        check_eq("b2b_dout_m", 32'(dout_m), 32'(rev(8'h55)));
        check_eq("b2b_ovr", 32'(ovr_l), 32'd0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        tick();

        check_eq("q_l_drained", 32'(q_l.size()), 32'd0);
        check_eq("q_m_drained", 32'(q_m.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
